// File: rtl/mdu_iter_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit.
package mdu_iter_pkg;

  localparam int MDU_ITER = 32;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } mdu_state_e;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One combinational restoring-divide step: shift remainder/quotient, trial subtract, select.
// Zero latency; no flow control.
module mdu_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] dvsr,
  output logic [XLEN-1:0] rem_nxt,
  output logic [XLEN-1:0] quo_nxt
);

  logic [XLEN:0]   shifted;
  logic            fits;
  logic [XLEN-1:0] trial;

  assign shifted = {rem, quo[XLEN-1]};
  assign fits    = shifted >= {1'b0, dvsr};
  // When the subtract succeeds the difference is below dvsr, so the wrapped low bits are exact.
  assign trial   = shifted[XLEN-1:0] - dvsr;
  assign rem_nxt = fits ? trial : shifted[XLEN-1:0];
  assign quo_nxt = {quo[XLEN-2:0], fits};

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M mul/div, radix-2; MDU_FAST_MUL_EN selects a single-cycle native multiply.
// Latency: done 33 edges after accept, 1 edge for div-by-zero/overflow (and fast multiplies).
// Backpressure: busy stalls the pipe; start is only taken in IDLE without a done pulse; flush aborts.
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  mdu_state_e        state_q, state_d;
  logic [2:0]        op_q;
  logic              neg_q;
  logic [XLEN-1:0]   m_q;
  logic [2*XLEN-1:0] p_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              done_q;
  logic [XLEN-1:0]   result_q;

  logic              accept, a_sgn, b_sgn, sa, sb, div_zero, ovf, special, fast;
  logic [XLEN-1:0]   ma, mb;
  logic [2*XLEN-1:0] fast_prod, p_mul, full;
  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   div_rem, div_quo, hi_fix, lo_fix, fin_res;

  assign accept   = (state_q == ST_IDLE) && start && !flush && !done_q;
  assign a_sgn    = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
                    (op == OP_DIV) || (op == OP_REM);
  assign b_sgn    = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  assign sa       = a_sgn & a[XLEN-1];
  assign sb       = b_sgn & b[XLEN-1];
  assign ma       = sa ? -a : a;
  assign mb       = sb ? -b : b;
  assign div_zero = is_div(op) && (b == '0);
  assign ovf      = ((op == OP_DIV) || (op == OP_REM)) &&
                    (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
  assign special  = div_zero || ovf;

`ifdef MDU_FAST_MUL_EN
  assign fast      = !is_div(op);
  assign fast_prod = {{XLEN{1'b0}}, ma} * {{XLEN{1'b0}}, mb};
`else
  assign fast      = 1'b0;
  assign fast_prod = '0;
`endif

  // Shift-add: multiplier sits in the low half and drains out as the product fills in.
  assign mul_sum = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, m_q} : '0);
  assign p_mul   = {mul_sum, p_q[XLEN-1:1]};

  mdu_div_step #(.XLEN(XLEN)) u_div_step (
    .rem     (p_q[2*XLEN-1:XLEN]),
    .quo     (p_q[XLEN-1:0]),
    .dvsr    (m_q),
    .rem_nxt (div_rem),
    .quo_nxt (div_quo)
  );

  always_comb begin
    full    = neg_q ? -p_q : p_q;
    hi_fix  = neg_q ? -p_q[2*XLEN-1:XLEN] : p_q[2*XLEN-1:XLEN];
    lo_fix  = neg_q ? -p_q[XLEN-1:0] : p_q[XLEN-1:0];
    fin_res = full[2*XLEN-1:XLEN];
    if (op_q == OP_MUL)
      fin_res = full[XLEN-1:0];
    else if (is_div(op_q))
      fin_res = op_q[1] ? hi_fix : lo_fix;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = (special || fast) ? ST_FIN : ST_RUN;
      ST_RUN:  if (cnt_q == CNT_W'(MDU_ITER - 1)) state_d = ST_FIN;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= '0;
      neg_q    <= 1'b0;
      m_q      <= '0;
      p_q      <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (!flush) begin
        case (state_q)
          ST_IDLE: if (accept) begin
            op_q  <= op;
            cnt_q <= '0;
            m_q   <= is_div(op) ? mb : ma;
            // Special results are preloaded as {remainder, quotient} so FIN needs no extra path.
            neg_q <= special ? 1'b0 : ((op == OP_REM) ? sa : (sa ^ sb));
            if (div_zero)       p_q <= {a, {XLEN{1'b1}}};
            else if (ovf)       p_q <= {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};
            else if (fast)      p_q <= fast_prod;
            else if (is_div(op)) p_q <= {{XLEN{1'b0}}, ma};
            else                p_q <= {{XLEN{1'b0}}, mb};
          end
          ST_RUN: begin
            cnt_q <= cnt_q + 1'b1;
            p_q   <= is_div(op_q) ? {div_rem, div_quo} : p_mul;
          end
          ST_FIN: begin
            result_q <= fin_res;
            done_q   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule
